// File: rtl/nv_checkpoint_ctrl.sv
// Checkpoint controller: backs up dirty register slots into a non-volatile shadow
// array and writes the shadow back on restore. Optional feature: BACKUP_SKIP_CLEAN_EN.
module nv_checkpoint_ctrl #(
    parameter int NSLOT  = 3,
    parameter int W      = 32,
    parameter int WR_LAT = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Backup_req,
    input  logic                 Restore_req,
    input  logic                 Nv_clr,
    input  logic [2*NSLOT-1:0]   Dirty_vals,
    output logic [NSLOT-1:0]     Backup_ens,
    output logic [NSLOT-1:0]     Backup_acks,
    input  logic [NSLOT*W-1:0]   Backup_Vouts,
    output logic [NSLOT-1:0]     Restore_ens,
    output logic [NSLOT*W-1:0]   Restore_Vins,
    output logic                 Stand_by,
    output logic                 Backup_done,
    output logic                 Restore_done
);

    localparam int               IW           = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [IW-1:0]    LP_LAST      = IW'(NSLOT - 1);
    localparam logic [IW-1:0]    LP_IDX_ONE   = IW'(1);
    localparam logic [3:0]       LP_WAIT_INIT = (WR_LAT > 0) ? 4'(WR_LAT - 1) : 4'd0;
    localparam logic [NSLOT-1:0] LP_ONE       = NSLOT'(1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BK_SCAN,
        ST_BK_EN,
        ST_BK_CAP,
        ST_BK_WAIT,
        ST_BK_ACK,
        ST_BK_DONE,
        ST_RS_SCAN,
        ST_RS_EN,
        ST_RS_DONE
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_idx;
    logic [3:0]         r_wait_cnt;
    logic [NSLOT-1:0]   r_backup_ens;
    logic [NSLOT-1:0]   r_backup_acks;
    logic [NSLOT-1:0]   r_restore_ens;
    logic               r_stand_by;
    logic               r_backup_done;
    logic               r_restore_done;
    logic [NSLOT-1:0]   r_valid;

    logic [NSLOT-1:0]   w_sel;
    logic               w_cap;
    logic               w_clr;
    logic               w_unused_dirty;

    // A capture coinciding with reset is dropped so the shadow never sees a half-aborted write.
    assign w_cap = (r_state == ST_BK_CAP) && !Rst;
    assign w_clr = (r_state == ST_IDLE) && Nv_clr;
    assign w_unused_dirty = ^Dirty_vals;

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            logic [W-1:0] r_shadow;

            always_ff @(posedge Clk) begin
                if (w_cap && (r_idx == IW'(gi))) begin
                    r_shadow <= Backup_Vouts[gi*W +: W];
                end
            end

            assign Restore_Vins[gi*W +: W] = r_valid[gi] ? r_shadow : '0;
`ifdef BACKUP_SKIP_CLEAN_EN
            assign w_sel[gi] = Dirty_vals[2*gi];
`else
            assign w_sel[gi] = 1'b1;
`endif
        end
    endgenerate

    // Valid bits survive Rst; only a clear requested while idle wipes them.
    always_ff @(posedge Clk) begin
        if (w_cap) begin
            r_valid[r_idx] <= 1'b1;
        end else if (w_clr) begin
            r_valid <= '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_wait_cnt     <= '0;
            r_backup_ens   <= '0;
            r_backup_acks  <= '0;
            r_restore_ens  <= '0;
            r_stand_by     <= 1'b0;
            r_backup_done  <= 1'b0;
            r_restore_done <= 1'b0;
        end else begin
            r_backup_ens   <= '0;
            r_backup_acks  <= '0;
            r_restore_ens  <= '0;
            r_backup_done  <= 1'b0;
            r_restore_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Backup_req) begin
                        r_state    <= ST_BK_SCAN;
                        r_idx      <= LP_LAST;
                        r_stand_by <= 1'b1;
                    end else if (Restore_req) begin
                        r_state    <= ST_RS_SCAN;
                        r_idx      <= LP_LAST;
                        r_stand_by <= 1'b1;
                    end
                end
                ST_BK_SCAN: begin
                    if (w_sel[r_idx]) begin
                        r_state      <= ST_BK_EN;
                        r_backup_ens <= LP_ONE << r_idx;
                    end else if (r_idx == '0) begin
                        r_state       <= ST_BK_DONE;
                        r_backup_done <= 1'b1;
                    end else begin
                        r_idx <= r_idx - LP_IDX_ONE;
                    end
                end
                ST_BK_EN: begin
                    r_state <= ST_BK_CAP;
                end
                ST_BK_CAP: begin
                    if (WR_LAT > 0) begin
                        r_state    <= ST_BK_WAIT;
                        r_wait_cnt <= LP_WAIT_INIT;
                    end else begin
                        r_state       <= ST_BK_ACK;
                        r_backup_acks <= LP_ONE << r_idx;
                    end
                end
                ST_BK_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state       <= ST_BK_ACK;
                        r_backup_acks <= LP_ONE << r_idx;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                ST_BK_ACK: begin
                    if (r_idx == '0) begin
                        r_state       <= ST_BK_DONE;
                        r_backup_done <= 1'b1;
                    end else begin
                        r_state <= ST_BK_SCAN;
                        r_idx   <= r_idx - LP_IDX_ONE;
                    end
                end
                ST_RS_SCAN: begin
                    if (r_valid[r_idx]) begin
                        r_state       <= ST_RS_EN;
                        r_restore_ens <= LP_ONE << r_idx;
                    end else if (r_idx == '0) begin
                        r_state        <= ST_RS_DONE;
                        r_restore_done <= 1'b1;
                    end else begin
                        r_idx <= r_idx - LP_IDX_ONE;
                    end
                end
                ST_RS_EN: begin
                    if (r_idx == '0) begin
                        r_state        <= ST_RS_DONE;
                        r_restore_done <= 1'b1;
                    end else begin
                        r_state <= ST_RS_SCAN;
                        r_idx   <= r_idx - LP_IDX_ONE;
                    end
                end
                ST_BK_DONE, ST_RS_DONE: begin
                    r_state    <= ST_IDLE;
                    r_stand_by <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_stand_by <= 1'b0;
                end
            endcase
        end
    end

    assign Backup_ens   = r_backup_ens;
    assign Backup_acks  = r_backup_acks;
    assign Restore_ens  = r_restore_ens;
    assign Stand_by     = r_stand_by;
    assign Backup_done  = r_backup_done;
    assign Restore_done = r_restore_done;

endmodule

// File: tb/tb_nv_checkpoint_ctrl.sv
// Self-checking bench for nv_checkpoint_ctrl: table vectors, directed corner
// sequences and random sequences checked cycle by cycle against a timeline model.
module tb_nv_checkpoint_ctrl;

    localparam int NSLOT  = 3;
    localparam int W      = 32;
    localparam int WR_LAT = 2;
    localparam int VW     = NSLOT * W;
`ifdef BACKUP_SKIP_CLEAN_EN
    localparam bit SKIP_CLEAN = 1'b1;
`else
    localparam bit SKIP_CLEAN = 1'b0;
`endif

    logic                 Clk;
    logic                 Rst;
    logic                 Backup_req;
    logic                 Restore_req;
    logic                 Nv_clr;
    logic [2*NSLOT-1:0]   Dirty_vals;
    logic [NSLOT-1:0]     Backup_ens;
    logic [NSLOT-1:0]     Backup_acks;
    logic [VW-1:0]        Backup_Vouts;
    logic [NSLOT-1:0]     Restore_ens;
    logic [VW-1:0]        Restore_Vins;
    logic                 Stand_by;
    logic                 Backup_done;
    logic                 Restore_done;

    nv_checkpoint_ctrl #(.NSLOT(NSLOT), .W(W), .WR_LAT(WR_LAT)) dut (
        .Clk(Clk), .Rst(Rst), .Backup_req(Backup_req), .Restore_req(Restore_req),
        .Nv_clr(Nv_clr), .Dirty_vals(Dirty_vals), .Backup_ens(Backup_ens),
        .Backup_acks(Backup_acks), .Backup_Vouts(Backup_Vouts), .Restore_ens(Restore_ens),
        .Restore_Vins(Restore_Vins), .Stand_by(Stand_by), .Backup_done(Backup_done),
        .Restore_done(Restore_done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model: shadow contents plus the cycle (1 = first busy cycle) of every pulse.
    logic [W-1:0] m_shadow [NSLOT];
    bit           m_valid  [NSLOT];
    int           en_c  [NSLOT];
    int           ack_c [NSLOT];
    int           rs_c  [NSLOT];

    typedef struct {
        int                 op;     // 0 clear, 1 backup, 2 restore
        logic [2*NSLOT-1:0] dirty;
        logic [VW-1:0]      vouts;
        int                 exp_done;
    } vec_t;

    task automatic check(input string name, input int cyc, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit slot_selected(input logic [2*NSLOT-1:0] dirty, input int i);
        return !SKIP_CLEAN || dirty[2*i];
    endfunction

    function automatic logic [NSLOT-1:0] exp_pulse(input int kind, input int cyc);
        logic [NSLOT-1:0] v;
        int c;
        v = '0;
        for (int i = 0; i < NSLOT; i++) begin
            c = (kind == 0) ? en_c[i] : ((kind == 1) ? ack_c[i] : rs_c[i]);
            if (c != 0 && c == cyc) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_vins();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (m_valid[i]) v[i*W +: W] = m_shadow[i];
        end
        return v;
    endfunction

    task automatic check_outputs(input int cyc, input bit sb, input logic [NSLOT-1:0] bke,
                                 input logic [NSLOT-1:0] bka, input logic [NSLOT-1:0] rse,
                                 input bit bd, input bit rd);
        check("stand_by",     cyc, VW'(Stand_by),     VW'(sb));
        check("backup_ens",   cyc, VW'(Backup_ens),   VW'(bke));
        check("backup_acks",  cyc, VW'(Backup_acks),  VW'(bka));
        check("restore_ens",  cyc, VW'(Restore_ens),  VW'(rse));
        check("backup_done",  cyc, VW'(Backup_done),  VW'(bd));
        check("restore_done", cyc, VW'(Restore_done), VW'(rd));
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_backup(input logic [2*NSLOT-1:0] dirty, input logic [VW-1:0] vouts,
                              input int abort_cyc, input int nvclr_cyc, output int seen_done);
        int t;
        int done_t;
        t = 1;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            en_c[i]  = 0;
            ack_c[i] = 0;
            rs_c[i]  = 0;
            if (slot_selected(dirty, i)) begin
                en_c[i]  = t + 1;
                ack_c[i] = t + 3 + WR_LAT;
                t += 4 + WR_LAT;
            end else begin
                t += 1;
            end
        end
        done_t     = t;
        seen_done  = -1;
        Dirty_vals   = dirty;
        Backup_Vouts = vouts;
        Backup_req   = 1'b1;
        for (int cyc = 1; cyc <= done_t + 1; cyc++) begin
            @(negedge Clk);
            if (Backup_done && seen_done < 0) seen_done = cyc;
            check_outputs(cyc, cyc <= done_t, exp_pulse(0, cyc), exp_pulse(1, cyc), '0,
                          cyc == done_t, 1'b0);
            if (cyc == 1) Backup_req = 1'b0;
            Nv_clr = (cyc == nvclr_cyc);
            if (cyc == abort_cyc) begin
                Rst = 1'b1;
                @(negedge Clk);
                Rst    = 1'b0;
                Nv_clr = 1'b0;
                check_outputs(cyc + 1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
                for (int i = 0; i < NSLOT; i++) begin
                    if (en_c[i] != 0 && en_c[i] + 1 < abort_cyc) begin
                        m_shadow[i] = vouts[i*W +: W];
                        m_valid[i]  = 1'b1;
                    end
                end
                return;
            end
        end
        for (int i = 0; i < NSLOT; i++) begin
            if (en_c[i] != 0) begin
                m_shadow[i] = vouts[i*W +: W];
                m_valid[i]  = 1'b1;
            end
        end
    endtask

    task automatic run_restore(input int raise_bk_cyc, output int seen_done);
        int t;
        int done_t;
        logic [VW-1:0] ev;
        t = 1;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            en_c[i]  = 0;
            ack_c[i] = 0;
            rs_c[i]  = 0;
            if (m_valid[i]) begin
                rs_c[i] = t + 1;
                t += 2;
            end else begin
                t += 1;
            end
        end
        done_t      = t;
        seen_done   = -1;
        ev          = exp_vins();
        Restore_req = 1'b1;
        for (int cyc = 1; cyc <= done_t + 1; cyc++) begin
            @(negedge Clk);
            if (Restore_done && seen_done < 0) seen_done = cyc;
            check_outputs(cyc, cyc <= done_t, '0, '0, exp_pulse(2, cyc), 1'b0, cyc == done_t);
            check("restore_vins", cyc, Restore_Vins, ev);
            if (cyc == 1) Restore_req = 1'b0;
            if (cyc == raise_bk_cyc) Backup_req = 1'b1;
        end
    endtask

    task automatic nvclr_idle();
        Nv_clr = 1'b1;
        @(negedge Clk);
        Nv_clr = 1'b0;
        for (int i = 0; i < NSLOT; i++) m_valid[i] = 1'b0;
        check("clr_stand_by", 0, VW'(Stand_by), '0);
        check("clr_vins", 0, Restore_Vins, exp_vins());
    endtask

    initial begin
        vec_t tbl [6];
        int   seen;
        logic [VW-1:0] v;
        int   r;
        int   ab;

        tbl[0] = '{0, 6'b000000, 96'h0, 0};
        tbl[1] = '{2, 6'b000000, 96'h0, 4};
        tbl[2] = '{1, 6'b010101, {32'hA5A5_0001, 32'h0000_0BEE, 32'hDEAD_BEEF}, 19};
        tbl[3] = '{2, 6'b000000, 96'h0, 7};
        tbl[4] = '{1, 6'b010101, {32'h1111_2222, 32'h3333_4444, 32'h5555_6666}, 19};
        tbl[5] = '{2, 6'b000000, 96'h0, 7};

        for (int i = 0; i < NSLOT; i++) begin
            m_shadow[i] = '0;
            m_valid[i]  = 1'b0;
            en_c[i] = 0; ack_c[i] = 0; rs_c[i] = 0;
        end
        Rst = 1'b1; Backup_req = 1'b0; Restore_req = 1'b0; Nv_clr = 1'b0;
        Dirty_vals = '0; Backup_Vouts = '0;
        repeat (3) @(negedge Clk);
        check_outputs(0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        Rst = 1'b0;
        @(negedge Clk);
        check_outputs(0, 1'b0, '0, '0, '0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            case (tbl[k].op)
                0: nvclr_idle();
                1: begin
                    run_backup(tbl[k].dirty, tbl[k].vouts, 0, 0, seen);
                    check("tbl_backup_done_cycle", k, VW'(seen), VW'(tbl[k].exp_done));
                end
                default: begin
                    run_restore(0, seen);
                    check("tbl_restore_done_cycle", k, VW'(seen), VW'(tbl[k].exp_done));
                end
            endcase
        end

        // Both requests together: backup first, then the still-pending restore.
        Restore_req = 1'b1;
        run_backup(6'b010101, {$urandom(), $urandom(), $urandom()}, 0, 0, seen);
        check("both_backup_done_cycle", 0, VW'(seen), VW'(19));
        run_restore(0, seen);
        check("both_restore_done_cycle", 0, VW'(seen), VW'(7));

        // Only slot 1 dirty.
        run_backup(6'b000100, {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}, 0, 0, seen);
        check("skip_done_cycle", 0, VW'(seen), VW'(SKIP_CLEAN ? 9 : 19));
        run_restore(0, seen);

        // Clear requested mid-backup is ignored.
        run_backup(6'b010101, {$urandom(), $urandom(), $urandom()}, 0, 5, seen);
        run_restore(0, seen);
        check("nvclr_busy_restore_done", 0, VW'(seen), VW'(7));

        // Backup requested during restore starts once the restore finishes.
        run_restore(2, seen);
        check("bk_during_rs_restore_done", 0, VW'(seen), VW'(7));
        run_backup(6'b010101, {$urandom(), $urandom(), $urandom()}, 0, 0, seen);
        check("bk_during_rs_backup_done", 0, VW'(seen), VW'(19));

        // Reset in the write wait of slot 2: slot 2 keeps the new data, no ack.
        run_backup(6'b010101, {32'h2222_ABCD, 32'h1111_ABCD, 32'h0000_ABCD}, 4, 0, seen);
        run_restore(0, seen);
        check("abort_restore_done", 0, VW'(seen), VW'(7));

        for (int it = 0; it < 30; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 1) begin
                nvclr_idle();
            end else if (r < 6) begin
                v  = {$urandom(), $urandom(), $urandom()};
                ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 12)) : 0;
                run_backup(6'($urandom()), v, ab, int'($urandom_range(0, 4)), seen);
            end else begin
                run_restore(0, seen);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
